// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM stage register with a 2-entry skid buffer; optional stall counter under STAGE_STALL_CNT_EN.
// Latency: 1 cycle when empty or popping. Backpressure: in_ready is a flop, low only while both entries are held.
// Flush empties the stage synchronously; rst clears everything asynchronously.
module exe_mem_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DEST_W-1:0] dest,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              mem_w,
    input  logic              mem_r,
    input  logic              wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DEST_W-1:0] dest_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic              mem_w_out,
    output logic              mem_r_out,
    output logic              wb_en_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] val_rm;
        logic [DATA_W-1:0] alu_res;
        logic              mem_w;
        logic              mem_r;
        logic              wb_en;
    } pld_t;

    // State value doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    pld_t   main_q, skid_q, in_pld;
    logic   in_ready_q;
    logic   accept, pop;
    logic   main_ld, main_from_skid, skid_ld;

    always_comb begin
        in_pld.dest    = dest;
        in_pld.val_rm  = val_rm;
        in_pld.alu_res = alu_res;
        in_pld.mem_w   = mem_w;
        in_pld.mem_r   = mem_r;
        in_pld.wb_en   = wb_en;
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;
    assign accept    = in_valid & in_ready_q & ~flush;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d = FULL;
                        skid_ld = 1'b1;
                    end else if (accept && pop) begin
                        main_ld = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
            if (main_ld) main_q <= main_from_skid ? skid_q : in_pld;
            if (skid_ld) skid_q <= in_pld;
        end
    end

    assign occupancy   = 2'(state_q);
    assign dest_out    = main_q.dest;
    assign val_rm_out  = main_q.val_rm;
    assign alu_res_out = main_q.alu_res;
    assign mem_w_out   = main_q.mem_w & out_valid;
    assign mem_r_out   = main_q.mem_r & out_valid;
    assign wb_en_out   = main_q.wb_en & out_valid;

`ifdef STAGE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Saturating; only rst clears it so stall history survives squashes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
